// File: rtl/hilo_muldiv.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit that produces the {HI,LO} write for the HI/LO register.
// A pipelined multiplier and a restoring radix-2 divider share one IDLE/MUL/DIV/DONE control FSM.
module hilo_muldiv #(
    parameter int MUL_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic [7:0]  aluop_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        flush_i,
    output logic        stall_req_o,
    output logic        busy_o,
    output logic        hilo_we_o,
    output logic [63:0] hilo_wdata_o
);

    localparam logic [7:0] MULT_OP  = 8'b0001_1000;
    localparam logic [7:0] MULTU_OP = 8'b0001_1001;
    localparam logic [7:0] DIV_OP   = 8'b0001_1010;
    localparam logic [7:0] DIVU_OP  = 8'b0001_1011;

    localparam logic [4:0] MUL_LAST = (MUL_LAT > 1) ? 5'(MUL_LAT - 2) : 5'd0;
    localparam logic [4:0] DIV_LAST = 5'd31;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    function automatic logic [31:0] magnitude(input logic [31:0] v, input logic sgn);
        return (sgn && v[31]) ? (~v + 32'd1) : v;
    endfunction

    function automatic logic [31:0] apply_sign(input logic [31:0] v, input logic neg);
        return neg ? (~v + 32'd1) : v;
    endfunction

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [63:0] held_q, held_d;

    logic        op_mul;
    logic        op_valid;
    logic        op_signed;
    logic        div_zero;
    logic        accept;
    logic [63:0] result;

    always_comb begin
        op_mul    = (aluop_i == MULT_OP) || (aluop_i == MULTU_OP);
        op_valid  = op_mul || (aluop_i == DIV_OP) || (aluop_i == DIVU_OP);
        op_signed = (aluop_i == MULT_OP) || (aluop_i == DIV_OP);
        div_zero  = (opdata2_i == 32'd0);
        accept    = (state_q == S_IDLE) && start_i && op_valid && !flush_i;
    end

    // ---------------- FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 5'd0;
            held_q  <= 64'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            held_q  <= held_d;
        end
    end

    // ---------------- FSM: next state
    always_comb begin
        state_d = state_q;
        cnt_d   = 5'd0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (op_mul) begin
                        state_d = (MUL_LAT == 1) ? S_DONE : S_MUL;
                    end else begin
                        state_d = div_zero ? S_DONE : S_DIV;
                    end
                end
            end
            S_MUL: begin
                cnt_d = cnt_q + 5'd1;
                if (flush_i) begin
                    state_d = S_IDLE;
                end else if (cnt_q == MUL_LAST) begin
                    state_d = S_DONE;
                end
            end
            S_DIV: begin
                cnt_d = cnt_q + 5'd1;
                if (flush_i) begin
                    state_d = S_IDLE;
                end else if (cnt_q == DIV_LAST) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs
    always_comb begin
        busy_o       = (state_q != S_IDLE);
        hilo_we_o    = (state_q == S_DONE) && !flush_i;
        stall_req_o  = accept || (((state_q == S_MUL) || (state_q == S_DIV)) && !flush_i);
        hilo_wdata_o = hilo_we_o ? result : held_q;
        held_d       = hilo_wdata_o;
    end

    // ---------------- Multiplier: stage 0 captures the product at accept, later stages delay it
    logic signed [32:0] mul_a;
    logic signed [32:0] mul_b;
    logic signed [63:0] mul_full;
    logic [63:0]        mul_pipe_q [MUL_LAT];
    logic [63:0]        mul_pipe_d [MUL_LAT];

    always_comb begin
        mul_a    = {op_signed & opdata1_i[31], opdata1_i};
        mul_b    = {op_signed & opdata2_i[31], opdata2_i};
        mul_full = 64'(mul_a) * 64'(mul_b);
        mul_pipe_d[0] = (accept && op_mul) ? mul_full : mul_pipe_q[0];
        for (int i = 1; i < MUL_LAT; i++) begin
            mul_pipe_d[i] = mul_pipe_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        mul_pipe_q <= mul_pipe_d;
    end

    // ---------------- Divider: magnitudes iterate, signs are re-applied in the write cycle
    logic [31:0] quo_q, quo_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] dvs_q, dvs_d;
    logic        qneg_q, qneg_d;
    logic        rneg_q, rneg_d;
    logic        is_mul_q, is_mul_d;
    logic [32:0] div_trial;

    always_comb begin
        quo_d     = quo_q;
        rem_d     = rem_q;
        dvs_d     = dvs_q;
        qneg_d    = qneg_q;
        rneg_d    = rneg_q;
        is_mul_d  = is_mul_q;
        div_trial = {rem_q, quo_q[31]};
        if (accept) begin
            is_mul_d = op_mul;
            if (!op_mul) begin
                // A zero divisor loads the final raw result with no sign fix-up.
                dvs_d  = magnitude(opdata2_i, op_signed);
                quo_d  = div_zero ? 32'hFFFF_FFFF : magnitude(opdata1_i, op_signed);
                rem_d  = div_zero ? opdata1_i : 32'd0;
                qneg_d = op_signed && !div_zero && (opdata1_i[31] ^ opdata2_i[31]);
                rneg_d = op_signed && !div_zero && opdata1_i[31];
            end
        end else if (state_q == S_DIV) begin
            if (div_trial >= {1'b0, dvs_q}) begin
                rem_d = 32'(div_trial - {1'b0, dvs_q});
                quo_d = {quo_q[30:0], 1'b1};
            end else begin
                rem_d = div_trial[31:0];
                quo_d = {quo_q[30:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk) begin
        quo_q    <= quo_d;
        rem_q    <= rem_d;
        dvs_q    <= dvs_d;
        qneg_q   <= qneg_d;
        rneg_q   <= rneg_d;
        is_mul_q <= is_mul_d;
    end

    always_comb begin
        result = is_mul_q ? mul_pipe_q[MUL_LAT-1]
                          : {apply_sign(rem_q, rneg_q), apply_sign(quo_q, qneg_q)};
    end

endmodule

// File: tb/tb_hilo_muldiv.sv
// Randomized bench for hilo_muldiv against a plain-arithmetic HI/LO reference model.
module tb_hilo_muldiv;

    localparam int MUL_LAT = 2;
    localparam logic [7:0] MULT_OP  = 8'b0001_1000;
    localparam logic [7:0] MULTU_OP = 8'b0001_1001;
    localparam logic [7:0] DIV_OP   = 8'b0001_1010;
    localparam logic [7:0] DIVU_OP  = 8'b0001_1011;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_i = 1'b0;
    logic [7:0]  aluop_i = 8'd0;
    logic [31:0] opdata1_i = 32'd0;
    logic [31:0] opdata2_i = 32'd0;
    logic        flush_i = 1'b0;
    logic        stall_req_o;
    logic        busy_o;
    logic        hilo_we_o;
    logic [63:0] hilo_wdata_o;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [63:0] exp_held = 64'd0;
    logic [7:0]  ops_tbl [4] = '{MULT_OP, MULTU_OP, DIV_OP, DIVU_OP};

    hilo_muldiv #(.MUL_LAT(MUL_LAT)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .aluop_i      (aluop_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .flush_i      (flush_i),
        .stall_req_o  (stall_req_o),
        .busy_o       (busy_o),
        .hilo_we_o    (hilo_we_o),
        .hilo_wdata_o (hilo_wdata_o)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] model(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] ua, ub;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'd0, a};
        ub = {32'd0, b};
        if (op == MULT_OP) return 64'(sa * sb);
        if (op == MULTU_OP) return ua * ub;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (op == DIV_OP) begin
            q = sa / sb;
            r = sa % sb;
        end else begin
            q = longint'(ua / ub);
            r = longint'(ua % ub);
        end
        return {r[31:0], q[31:0]};
    endfunction

    function automatic int latency(input logic [7:0] op, input logic [31:0] b);
        if (op == MULT_OP || op == MULTU_OP) return MUL_LAT;
        return (b == 32'd0) ? 1 : 33;
    endfunction

    // Drives one operation and records what the DUT did; callers decide pass/fail.
    task automatic run_op(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit b2b, output int we_cyc, output int we_cnt,
                          output logic [63:0] wd, output int ctl_bad);
        int lat, last;
        logic [63:0] expv;
        lat = latency(op, b);
        last = b2b ? lat : lat + 1;
        expv = model(op, a, b);
        we_cyc = -1; we_cnt = 0; wd = 64'd0; ctl_bad = 0;
        @(posedge clk); #1;
        start_i = 1'b1; aluop_i = op; opdata1_i = a; opdata2_i = b; flush_i = 1'b0;
        @(negedge clk);
        if (stall_req_o !== 1'b1 || hilo_we_o !== 1'b0 || busy_o !== 1'b0) ctl_bad++;
        for (int k = 1; k <= last; k++) begin
            @(posedge clk); #1;
            start_i   = (k < lat) ? 1'($urandom_range(0, 1)) : 1'b0;
            aluop_i   = ops_tbl[$urandom_range(0, 3)];
            opdata1_i = $urandom;
            opdata2_i = $urandom;
            @(negedge clk);
            if (hilo_we_o === 1'b1) begin
                we_cnt++;
                if (we_cyc < 0) begin
                    we_cyc = k;
                    wd = hilo_wdata_o;
                end
            end
            if (stall_req_o !== 1'(k < lat)) ctl_bad++;
            if (busy_o !== 1'(k <= lat)) ctl_bad++;
            if (k > lat && hilo_wdata_o !== expv) ctl_bad++;
        end
        start_i = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (hilo_we_o !== 1'b0 || busy_o !== 1'b0 || stall_req_o !== 1'b0 || hilo_wdata_o !== 64'd0) begin
            n_bad++;
            $display("FAIL reset: we=%b busy=%b stall=%b wdata=%h, want all 0", hilo_we_o, busy_o, stall_req_o, hilo_wdata_o);
        end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (busy_o !== 1'b0 || hilo_wdata_o !== 64'd0) begin
            n_bad++;
            $display("FAIL post_reset: busy=%b wdata=%h, want 0 and 0", busy_o, hilo_wdata_o);
        end
    endtask

    task automatic test_ignored_op();
        @(posedge clk); #1;
        start_i = 1'b1; aluop_i = 8'h21; opdata1_i = 32'd9; opdata2_i = 32'd3;
        @(negedge clk);
        n_cmp++;
        if (stall_req_o !== 1'b0) begin
            n_bad++;
            $display("FAIL nonmd_stall: stall=%b, want 0", stall_req_o);
        end
        @(posedge clk); #1;
        start_i = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (busy_o !== 1'b0) begin
            n_bad++;
            $display("FAIL nonmd_busy: busy=%b, want 0", busy_o);
        end
    endtask

    task automatic test_mul();
        logic [31:0] a, b;
        logic [7:0] op;
        int wc, wn, cb;
        logic [63:0] wd, ev;
        for (int i = 0; i < 12; i++) begin
            op = (i % 2 == 0) ? MULT_OP : MULTU_OP;
            a = $urandom; b = $urandom;
            if (i == 0) begin a = 32'hFFFF_FFFE; b = 32'd3; end
            if (i == 1) begin a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; end
            if (i == 2) begin a = 32'h8000_0000; b = 32'h8000_0000; end
            ev = model(op, a, b);
            run_op(op, a, b, 1'b0, wc, wn, wd, cb);
            exp_held = ev;
            n_cmp++;
            if (wd !== ev || wc !== MUL_LAT || wn !== 1 || cb !== 0) begin
                n_bad++;
                $display("FAIL mul op=%h a=%h b=%h: wdata=%h we_cyc=%0d we_cnt=%0d ctl_err=%0d, want %h %0d 1 0",
                         op, a, b, wd, wc, wn, cb, ev, MUL_LAT);
            end
        end
    endtask

    task automatic test_div();
        logic [31:0] a, b;
        logic [7:0] op;
        int wc, wn, cb;
        logic [63:0] wd, ev;
        for (int i = 0; i < 12; i++) begin
            op = (i % 2 == 0) ? DIV_OP : DIVU_OP;
            a = $urandom;
            b = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(1, 50));
            if (b == 32'd0) b = 32'd1;
            if (i == 0) begin a = 32'hFFFF_FFF9; b = 32'd2; end
            if (i == 1) begin a = 32'd100; b = 32'd7; end
            if (i == 2) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            if (i == 4) begin a = 32'd7; b = 32'hFFFF_FFFE; end
            ev = model(op, a, b);
            run_op(op, a, b, 1'b0, wc, wn, wd, cb);
            exp_held = ev;
            n_cmp++;
            if (wd !== ev || wc !== 33 || wn !== 1 || cb !== 0) begin
                n_bad++;
                $display("FAIL div op=%h a=%h b=%h: wdata=%h we_cyc=%0d we_cnt=%0d ctl_err=%0d, want %h 33 1 0",
                         op, a, b, wd, wc, wn, cb, ev);
            end
        end
    endtask

    task automatic test_div_zero();
        logic [31:0] a;
        logic [7:0] op;
        int wc, wn, cb;
        logic [63:0] wd;
        for (int i = 0; i < 4; i++) begin
            op = (i % 2 == 0) ? DIV_OP : DIVU_OP;
            a = (i == 0) ? 32'd5 : $urandom;
            run_op(op, a, 32'd0, 1'b0, wc, wn, wd, cb);
            exp_held = {a, 32'hFFFF_FFFF};
            n_cmp++;
            if (wd !== {a, 32'hFFFF_FFFF} || wc !== 1 || wn !== 1 || cb !== 0) begin
                n_bad++;
                $display("FAIL div_zero op=%h a=%h: wdata=%h we_cyc=%0d we_cnt=%0d ctl_err=%0d, want %h 1 1 0",
                         op, a, wd, wc, wn, cb, {a, 32'hFFFF_FFFF});
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] op;
        logic [31:0] a, b;
        int wc, wn, cb;
        logic [63:0] wd, ev;
        for (int i = 0; i < 6; i++) begin
            op = ops_tbl[$urandom_range(0, 3)];
            a = $urandom;
            b = (i == 3) ? 32'd0 : $urandom;
            ev = model(op, a, b);
            run_op(op, a, b, (i != 5), wc, wn, wd, cb);
            exp_held = ev;
            n_cmp++;
            if (wd !== ev || wc !== latency(op, b) || wn !== 1 || cb !== 0) begin
                n_bad++;
                $display("FAIL b2b[%0d] op=%h a=%h b=%h: wdata=%h we_cyc=%0d we_cnt=%0d ctl_err=%0d, want %h %0d 1 0",
                         i, op, a, b, wd, wc, wn, cb, ev, latency(op, b));
            end
        end
    endtask

    task automatic test_flush();
        int wc, wn, cb, late_we;
        logic [63:0] wd, ev;
        logic [31:0] a, b;
        // Flush in the middle of a divide.
        @(posedge clk); #1;
        start_i = 1'b1; aluop_i = DIV_OP; opdata1_i = $urandom; opdata2_i = $urandom | 32'd1;
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk); #1;
            start_i = 1'b0;
        end
        @(posedge clk); #1;
        flush_i = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (hilo_we_o !== 1'b0 || hilo_wdata_o !== exp_held) begin
            n_bad++;
            $display("FAIL flush_div_cycle: we=%b wdata=%h, want 0 %h", hilo_we_o, hilo_wdata_o, exp_held);
        end
        @(posedge clk); #1;
        flush_i = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (busy_o !== 1'b0 || stall_req_o !== 1'b0) begin
            n_bad++;
            $display("FAIL flush_div_after: busy=%b stall=%b, want 0 0", busy_o, stall_req_o);
        end
        a = $urandom; b = $urandom;
        ev = model(MULT_OP, a, b);
        run_op(MULT_OP, a, b, 1'b0, wc, wn, wd, cb);
        exp_held = ev;
        n_cmp++;
        if (wd !== ev || wc !== MUL_LAT || wn !== 1 || cb !== 0) begin
            n_bad++;
            $display("FAIL flush_then_mult: wdata=%h we_cyc=%0d we_cnt=%0d ctl_err=%0d, want %h %0d 1 0",
                     wd, wc, wn, cb, ev, MUL_LAT);
        end
        late_we = 0;
        repeat (25) begin
            @(negedge clk);
            if (hilo_we_o !== 1'b0 || hilo_wdata_o !== exp_held) late_we++;
        end
        n_cmp++;
        if (late_we !== 0) begin
            n_bad++;
            $display("FAIL flush_stale_write: bad_cycles=%0d, want 0", late_we);
        end
        // Flush in the write cycle of a multiply.
        @(posedge clk); #1;
        start_i = 1'b1; aluop_i = MULTU_OP; opdata1_i = $urandom | 32'd1; opdata2_i = 32'd3;
        for (int k = 1; k < MUL_LAT; k++) begin
            @(posedge clk); #1;
            start_i = 1'b0;
        end
        @(posedge clk); #1;
        start_i = 1'b0; flush_i = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (hilo_we_o !== 1'b0 || hilo_wdata_o !== exp_held) begin
            n_bad++;
            $display("FAIL flush_write_cycle: we=%b wdata=%h, want 0 %h", hilo_we_o, hilo_wdata_o, exp_held);
        end
        // Flush coinciding with a start: nothing is accepted.
        @(posedge clk); #1;
        start_i = 1'b1; aluop_i = DIV_OP; flush_i = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (stall_req_o !== 1'b0) begin
            n_bad++;
            $display("FAIL flush_accept_stall: stall=%b, want 0", stall_req_o);
        end
        @(posedge clk); #1;
        start_i = 1'b0; flush_i = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (busy_o !== 1'b0 || hilo_wdata_o !== exp_held) begin
            n_bad++;
            $display("FAIL flush_accept_busy: busy=%b wdata=%h, want 0 %h", busy_o, hilo_wdata_o, exp_held);
        end
    endtask

    task automatic test_reset_mid();
        int wc, wn, cb, late_we;
        logic [63:0] wd, ev;
        @(posedge clk); #1;
        start_i = 1'b1; aluop_i = DIV_OP; opdata1_i = 32'd1000; opdata2_i = 32'd7;
        repeat (5) begin
            @(posedge clk); #1;
            start_i = 1'b0;
        end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (busy_o !== 1'b0 || hilo_we_o !== 1'b0 || stall_req_o !== 1'b0 || hilo_wdata_o !== 64'd0) begin
            n_bad++;
            $display("FAIL reset_mid: busy=%b we=%b stall=%b wdata=%h, want all 0", busy_o, hilo_we_o, stall_req_o, hilo_wdata_o);
        end
        @(negedge clk);
        rst = 1'b0;
        exp_held = 64'd0;
        late_we = 0;
        repeat (35) begin
            @(negedge clk);
            if (hilo_we_o !== 1'b0 || busy_o !== 1'b0) late_we++;
        end
        n_cmp++;
        if (late_we !== 0) begin
            n_bad++;
            $display("FAIL reset_mid_after: bad_cycles=%0d, want 0", late_we);
        end
        ev = model(DIVU_OP, 32'd100, 32'd7);
        run_op(DIVU_OP, 32'd100, 32'd7, 1'b0, wc, wn, wd, cb);
        exp_held = ev;
        n_cmp++;
        if (wd !== ev || wc !== 33 || wn !== 1 || cb !== 0) begin
            n_bad++;
            $display("FAIL reset_mid_recover: wdata=%h we_cyc=%0d we_cnt=%0d ctl_err=%0d, want %h 33 1 0",
                     wd, wc, wn, cb, ev);
        end
    endtask

    initial begin
        test_reset();
        test_ignored_op();
        test_mul();
        test_div();
        test_div_zero();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
